// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: FSM states, program count
// and the table of core entry addresses launched in order.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_RECORD,
    ST_DONE
  } seq_state_t;

  localparam int NUM_PROG = 3;
  localparam int START_W  = 16;

  localparam logic [START_W-1:0] PROG_START [NUM_PROG] = '{16'h0040, 16'h0120, 16'h0200};

  // Unlisted program slots launch from address zero.
  function automatic logic [START_W-1:0] prog_start(input logic [1:0] idx);
    if (int'(idx) < NUM_PROG) return PROG_START[idx];
    return '0;
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Sequencer-to-core control link: core reset, core start address and the core halt flag.
interface program_sequencer_if #(
  parameter int PC_W = 10
);
  logic            core_rst;
  logic [PC_W-1:0] core_pc_init;
  logic            core_done;

  modport master (output core_rst, output core_pc_init, input core_done);
  modport slave  (input core_rst, input core_pc_init, output core_done);
endinterface

// File: rtl/cycle_counter.sv
// Run-cycle counter with synchronous clear (priority over enable) that sticks at all-ones
// instead of wrapping.
module cycle_counter #(
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [CYC_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CYC_W'(1);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Runs NUM_PROG core programs back-to-back, holding the core in reset between launches
// and recording how many cycles each program ran (or flagging a timeout).
module program_sequencer
  import seq_pkg::*;
#(
  parameter int          NUM_PROG = seq_pkg::NUM_PROG,
  parameter int          PC_W     = 10,
  parameter int          CYC_W    = 16,
  parameter int unsigned TIMEOUT  = 32'h0000FFF0,
  parameter int          RST_CYC  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  program_sequencer_if.master  core,
  output logic [1:0]           prog_idx,
  output logic                 busy,
  output logic                 done,
  input  logic [1:0]           cyc_sel,
  output logic [CYC_W-1:0]     cyc_out,
  output logic [NUM_PROG-1:0]  timeout_flags
);

  localparam int LW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  seq_state_t       state;
  logic [LW-1:0]    launch_cnt;
  logic [CYC_W-1:0] counts [NUM_PROG];
  logic [CYC_W-1:0] run_count;
  logic             first_run;
  logic             hit_timeout;
  logic             last_prog;

  cycle_counter #(.CYC_W(CYC_W)) u_run_counter (
    .clk   (clk),
    .reset (reset),
    .en    (state == ST_RUN),
    .clr   (state != ST_RUN),
    .count (run_count)
  );

  // The counter is zero only on the first RUN cycle, where a stale halt must be ignored.
  assign first_run   = (run_count == '0);
  assign hit_timeout = (64'(run_count) + 64'd1) >= 64'(TIMEOUT);
  assign last_prog   = (prog_idx == 2'(NUM_PROG - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      prog_idx          <= '0;
      launch_cnt        <= '0;
      core.core_rst     <= 1'b1;
      core.core_pc_init <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      timeout_flags     <= '0;
      for (int i = 0; i < NUM_PROG; i++) counts[i] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state             <= ST_LAUNCH;
            prog_idx          <= '0;
            launch_cnt        <= '0;
            core.core_pc_init <= PC_W'(prog_start(2'd0));
            busy              <= 1'b1;
            done              <= 1'b0;
            timeout_flags     <= '0;
            for (int i = 0; i < NUM_PROG; i++) counts[i] <= '0;
          end
        end
        ST_LAUNCH: begin
          if (launch_cnt == LW'(RST_CYC - 1)) begin
            state         <= ST_RUN;
            core.core_rst <= 1'b0;
          end else begin
            launch_cnt <= launch_cnt + LW'(1);
          end
        end
        ST_RUN: begin
          if (core.core_done && !first_run) begin
            state         <= ST_RECORD;
            core.core_rst <= 1'b1;
          end else if (hit_timeout) begin
            state                   <= ST_RECORD;
            core.core_rst           <= 1'b1;
            timeout_flags[prog_idx] <= 1'b1;
          end
        end
        ST_RECORD: begin
          counts[prog_idx] <= run_count;
          if (last_prog) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state             <= ST_LAUNCH;
            prog_idx          <= prog_idx + 2'd1;
            launch_cnt        <= '0;
            core.core_pc_init <= PC_W'(prog_start(prog_idx + 2'd1));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cyc_out = '0;
    if (int'(cyc_sel) < NUM_PROG) cyc_out = counts[cyc_sel];
  end

endmodule
